axis_burst_writer: RTL and testbench

- AXI4 write master that sits directly upstream of the AXI4 RAM slave in vex_soc.
- Accepts a command (start byte address, word count) and an AXI-Stream data source.
- Splits the transfer into INCR bursts and drives the slave's AW/W/B channels.
- Reports completion and any error response to the controlling logic.

---
 rtl/axis_burst_writer.sv | 209 ++++++++++++++++++++
 tb/tb_axis_burst_writer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_burst_writer.sv
// AXI4 write master: turns a (start address, word count) command plus an
// AXI-Stream source into INCR bursts on AW/W/B, one burst outstanding.
module axis_burst_writer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH      = 8,
  parameter int unsigned AXI_ID        = 0,
  parameter int unsigned MAX_BURST_LEN = 16,
  parameter int unsigned LEN_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned SIZE_LOG2 = $clog2(STRB_WIDTH);
  localparam int unsigned PAGE_BITS = (ADDR_WIDTH < 12) ? ADDR_WIDTH : 12;
  localparam bit          HAS_PAGE  = (ADDR_WIDTH >= 12);
  localparam int unsigned BEAT_W    = 9;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << SIZE_LOG2) - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [BEAT_W-1:0]     beats_q, beats_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [7:0]            awlen_q, awlen_d;
  logic                  err_acc_q, err_acc_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wlast_q, wlast_d;
  logic                  bready_q, bready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  w_fire;
  logic                  unused_bid;

  // Beats of the next burst: limited by words left, burst cap and 4KB page end.
  function automatic logic [BEAT_W-1:0] calc_beats(input logic [ADDR_WIDTH-1:0] a,
                                                   input logic [LEN_WIDTH-1:0]  rem);
    logic [31:0] n;
    logic [31:0] page_words;
    n          = 32'(rem);
    page_words = '0;
    if (n > 32'(MAX_BURST_LEN)) n = 32'(MAX_BURST_LEN);
    if (HAS_PAGE) begin
      page_words = (32'd4096 - 32'(a[PAGE_BITS-1:0])) >> SIZE_LOG2;
      if (n > page_words) n = page_words;
    end
    return BEAT_W'(n);
  endfunction

  assign w_fire     = (state_q == ST_W) && s_axis_tvalid && m_axi_wready;
  assign unused_bid = &{1'b0, m_axi_bid};

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    beat_cnt_d  = beat_cnt_q;
    awlen_d     = awlen_q;
    err_acc_d   = err_acc_q;
    wlast_d     = wlast_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr & ALIGN_MASK;
          remaining_d = cmd_len;
          err_acc_d   = 1'b0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_AW;
            beats_d = calc_beats(cmd_addr & ALIGN_MASK, cmd_len);
            awlen_d = 8'(beats_d - 9'd1);
          end
        end
      end
      ST_AW: begin
        if (m_axi_awready) begin
          state_d    = ST_W;
          beat_cnt_d = beats_q;
          wlast_d    = (beats_q == 9'd1);
        end
      end
      ST_W: begin
        if (w_fire) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          wlast_d    = (beat_cnt_q == 9'd2);
          if (beat_cnt_q == 9'd1) begin
            addr_d      = addr_q + ADDR_WIDTH'(32'(beats_q) << SIZE_LOG2);
            remaining_d = remaining_q - LEN_WIDTH'(beats_q);
            wlast_d     = 1'b0;
            state_d     = ST_B;
          end
        end
      end
      ST_B: begin
        if (m_axi_bvalid) begin
          err_acc_d = err_acc_q | (m_axi_bresp != 2'b00);
          if (remaining_q != '0) begin
            state_d = ST_AW;
            beats_d = calc_beats(addr_q, remaining_q);
            awlen_d = 8'(beats_d - 9'd1);
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            error_d = err_acc_d;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    awvalid_d   = (state_d == ST_AW);
    bready_d    = (state_d == ST_B);
    cmd_ready_d = (state_d == ST_IDLE);
    // Leaving B is always the done cycle, which still counts as busy.
    busy_d      = (state_d != ST_IDLE) || (state_q == ST_B);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      awlen_q     <= '0;
      err_acc_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      awlen_q     <= awlen_d;
      err_acc_q   <= err_acc_d;
      awvalid_q   <= awvalid_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_axi_awid    = ID_WIDTH'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast_q;
  // Stream and W channel are wired straight through while a burst is open.
  assign m_axi_wvalid  = (state_q == ST_W) && s_axis_tvalid;
  assign s_axis_tready = (state_q == ST_W) && m_axi_wready;
  assign m_axi_bready  = bready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_axis_burst_writer.sv
// Bench for axis_burst_writer: directed and random commands against a
// behavioural burst-splitting model and a simple AXI slave / stream source.
module tb_axis_burst_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axi_awid;
  logic [15:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  axis_burst_writer dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [7:0]  id;
  } aw_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_t;

  aw_t         aw_log[$];
  w_t          w_log[$];
  aw_t         exp_aw[$];
  logic [31:0] exp_data[$];
  logic        exp_last[$];
  logic [31:0] stream_q[$];

  int errors = 0;
  int checks = 0;
  int tv_mode = 0, wr_mode = 0, awr_mode = 0, b_mode = 0;
  int bad_idx = -1;
  int b_count = 0;
  int b_pending = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // AXI slave and stream source: sample handshakes at negedge, drive after posedge.
  initial begin
    bit aw_f, w_f, t_f, b_f, avail;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_bid     = '0;
    forever begin
      @(negedge clk);
      aw_f = m_axi_awvalid && m_axi_awready;
      w_f  = m_axi_wvalid && m_axi_wready;
      t_f  = s_axis_tvalid && s_axis_tready;
      b_f  = m_axi_bvalid && m_axi_bready;
      if (rst) begin
        if (aw_f) aw_log.push_back({m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awid});
        if (w_f) w_log.push_back({m_axi_wdata, m_axi_wstrb, m_axi_wlast});
        if (s_axis_tready) chk("tready_needs_wready", 32'(m_axi_wready), 32'd1);
        if (w_f || t_f) chk("w_fire_eq_t_fire", 32'(w_f), 32'(t_f));
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        b_pending     = 0;
        s_axis_tvalid = 1'b0;
        m_axi_bvalid  = 1'b0;
      end else begin
        if (t_f && stream_q.size() > 0) void'(stream_q.pop_front());
        if (w_f && m_axi_wlast) b_pending++;
        if (b_f) begin
          m_axi_bvalid = 1'b0;
          b_pending--;
        end
        avail = (stream_q.size() > 0);
        case (tv_mode)
          0:       s_axis_tvalid = avail;
          1:       s_axis_tvalid = avail && (cyc % 2 == 0);
          default: s_axis_tvalid = avail && ($urandom_range(0, 1) == 1);
        endcase
        s_axis_tdata = avail ? stream_q[0] : 32'h0;
        case (wr_mode)
          0:       m_axi_wready = 1'b1;
          1:       m_axi_wready = (cyc % 4 == 1) || (cyc % 4 == 2);
          default: m_axi_wready = ($urandom_range(0, 1) == 1);
        endcase
        m_axi_awready = (awr_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        if (!m_axi_bvalid && b_pending > 0 && (b_mode == 0 || $urandom_range(0, 2) == 0)) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = (b_count == bad_idx) ? 2'b10 : 2'b00;
          b_count++;
        end
      end
    end
  end

  // Reference: split a command into INCR bursts from the address/length rules.
  task automatic model_bursts(input int addr, input int len);
    int a, rem, b, pw;
    exp_aw.delete();
    exp_last.delete();
    a   = addr & 'hFFFC;
    rem = len;
    while (rem > 0) begin
      b  = (rem > 16) ? 16 : rem;
      pw = (4096 - (a % 4096)) / 4;
      if (b > pw) b = pw;
      exp_aw.push_back({16'(a), 8'(b - 1), 3'd2, 2'b01, 8'd0});
      for (int k = 0; k < b; k++) exp_last.push_back(k == b - 1);
      a   = (a + b * 4) % 65536;
      rem = rem - b;
    end
  endtask

  // Issue one command and check the whole resulting transaction.
  task automatic run_cmd(input int addr, input int len, input int bad, input bit seq_data);
    logic [31:0] d;
    int  n, na, nw;
    bit  got, prev_b, exp_err;
    model_bursts(addr, len);
    exp_data.delete();
    aw_log.delete();
    w_log.delete();
    b_count = 0;
    bad_idx = bad;
    exp_err = (bad >= 0) && (bad < exp_aw.size());
    for (int i = 0; i < len; i++) begin
      d = seq_data ? 32'(i + 1) : $urandom;
      exp_data.push_back(d);
      stream_q.push_back(d);
    end
    @(posedge clk);
    #1;
    cmd_addr  = 16'(addr);
    cmd_len   = 16'(len);
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("cmd_ready_seen", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    if (len == 0) begin
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_error", 32'(error), 32'd0);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_awvalid", 32'(m_axi_awvalid), 32'd0);
      @(negedge clk);
      chk("zero_done_pulse", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      chk("zero_aw_count", 32'(aw_log.size()), 32'd0);
      return;
    end
    chk("awvalid_after_cmd", 32'(m_axi_awvalid), 32'd1);
    got    = 1'b0;
    prev_b = 1'b0;
    for (n = 0; n < 3000; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      chk("error_outside_done", 32'(error), 32'd0);
      chk("busy_during_cmd", 32'(busy), 32'd1);
      prev_b = m_axi_bvalid && m_axi_bready;
      @(negedge clk);
    end
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("done_after_b", 32'(prev_b), 32'd1);
      chk("done_error", 32'(error), 32'(exp_err));
      chk("busy_in_done", 32'(busy), 32'd1);
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("cmd_ready_after_done", 32'(cmd_ready), 32'd1);
    end
    chk("aw_count", 32'(aw_log.size()), 32'(exp_aw.size()));
    na = (aw_log.size() < exp_aw.size()) ? aw_log.size() : exp_aw.size();
    for (int i = 0; i < na; i++) begin
      chk($sformatf("awaddr[%0d]", i), 32'(aw_log[i].addr), 32'(exp_aw[i].addr));
      chk($sformatf("awlen[%0d]", i), 32'(aw_log[i].len), 32'(exp_aw[i].len));
      chk($sformatf("awsize[%0d]", i), 32'(aw_log[i].size), 32'd2);
      chk($sformatf("awburst[%0d]", i), 32'(aw_log[i].burst), 32'd1);
      chk($sformatf("awid[%0d]", i), 32'(aw_log[i].id), 32'd0);
    end
    chk("w_count", 32'(w_log.size()), 32'(len));
    nw = (w_log.size() < len) ? w_log.size() : len;
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("wdata[%0d]", i), w_log[i].data, exp_data[i]);
      chk($sformatf("wlast[%0d]", i), 32'(w_log[i].last), 32'(exp_last[i]));
      chk($sformatf("wstrb[%0d]", i), 32'(w_log[i].strb), 32'hF);
    end
    chk("stream_drained", 32'(stream_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_valid = 1'b0;
    #3;
    chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("rst_bready", 32'(m_axi_bready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    #10;
    rst = 1'b1;
    #1;
    chk("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("cmd_ready_after_edge", 32'(cmd_ready), 32'd1);

    run_cmd('h0100, 4, -1, 1'b0);
    run_cmd('h0000, 40, -1, 1'b0);
    run_cmd('h0FF8, 8, -1, 1'b0);
    run_cmd('h0203, 3, -1, 1'b0);
    tv_mode = 1;
    wr_mode = 1;
    run_cmd('h0400, 5, -1, 1'b1);
    tv_mode = 0;
    wr_mode = 0;
    run_cmd('h0800, 48, 1, 1'b0);
    run_cmd('h0800, 48, -1, 1'b0);
    run_cmd('h1234, 0, -1, 1'b0);
    run_cmd('hFFF0, 10, -1, 1'b0);

    // Reset in the middle of a W burst.
    wr_mode = 1;
    for (int i = 0; i < 20; i++) stream_q.push_back($urandom);
    @(posedge clk);
    #1;
    cmd_addr  = 16'h2000;
    cmd_len   = 16'd20;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m_axi_wvalid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("wvalid_before_reset", 32'(m_axi_wvalid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("reset_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("reset_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    stream_q.delete();
    aw_log.delete();
    w_log.delete();
    wr_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("cmd_ready_after_release", 32'(cmd_ready), 32'd1);
    run_cmd('h3000, 6, -1, 1'b0);

    // Randomised commands and handshake timing.
    for (int t = 0; t < 10; t++) begin
      tv_mode  = 2;
      wr_mode  = $urandom_range(0, 2);
      awr_mode = $urandom_range(0, 1);
      b_mode   = $urandom_range(0, 1);
      run_cmd(int'($urandom_range(0, 65535)), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 4)) - 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
